channel_accum: RTL

- Integrate-and-dump stage of one imitator/correlator channel.
- Sits directly downstream of the channel code delay register.
- Multiplies baseband I/Q samples by the delayed prompt code (and, optionally, the early and late codes), then accumulates over one code epoch.
- On each delayed epoch pulse it dumps the sums to holding registers, which are read out through a valid/ack handshake.

---
 rtl/channel_accum_if.sv | 41 ++++
 rtl/channel_accum.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/channel_accum_if.sv
// Result readout bundle of one correlator channel: latched sums, counters, status and ack.
// master drives results/status (the accumulator), slave is the consumer and drives rd_ack.
// Ports (signals): p_i/p_q [e_i/e_q/l_i/l_q with EARLY_LATE_EN], n_samp, epoch_cnt, sat,
// result_valid, overrun, rd_ack.
interface channel_accum_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
);
    logic signed [ACC_W-1:0] p_i;
    logic signed [ACC_W-1:0] p_q;
`ifdef EARLY_LATE_EN
    logic signed [ACC_W-1:0] e_i;
    logic signed [ACC_W-1:0] e_q;
    logic signed [ACC_W-1:0] l_i;
    logic signed [ACC_W-1:0] l_q;
`endif
    logic [CNT_W-1:0]        n_samp;
    logic [CNT_W-1:0]        epoch_cnt;
    logic                    sat;
    logic                    result_valid;
    logic                    overrun;
    logic                    rd_ack;

    modport master (
        output p_i, p_q,
`ifdef EARLY_LATE_EN
        output e_i, e_q, l_i, l_q,
`endif
        output n_samp, epoch_cnt, sat, result_valid, overrun,
        input  rd_ack
    );

    modport slave (
        input  p_i, p_q,
`ifdef EARLY_LATE_EN
        input  e_i, e_q, l_i, l_q,
`endif
        input  n_samp, epoch_cnt, sat, result_valid, overrun,
        output rd_ack
    );
endinterface

// File: rtl/channel_accum.sv
// Integrate-and-dump for one correlator channel: code-wipe I/Q, saturating accumulate per epoch.
// Latency: dumped sums visible 1 clk after the dly_epoch cycle; first pulse after enable only arms.
// Backpressure: none on samples; an unacked result is overwritten on the next dump (sticky overrun).
// Ports: clk, reset_n (async, active-low), ch_en, i_in/q_in, promt_code, dly_epoch,
// [early_code/late_code], res (channel_accum_if.master: results, status, rd_ack).
// Optional macro EARLY_LATE_EN adds the early/late code inputs and four more accumulators.
// Requires ACC_W >= IN_W + 2 so a single product always fits in the accumulator with headroom.
module channel_accum #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ch_en,
    input  logic signed [IN_W-1:0] i_in,
    input  logic signed [IN_W-1:0] q_in,
    input  logic                   promt_code,
`ifdef EARLY_LATE_EN
    input  logic                   early_code,
    input  logic                   late_code,
`endif
    input  logic                   dly_epoch,
    channel_accum_if.master        res
);
    // Lane order: 0 p_i, 1 p_q, 2 e_i, 3 e_q, 4 l_i, 5 l_q (even lanes take I, odd lanes Q).
`ifdef EARLY_LATE_EN
    localparam int NL = 6;
`else
    localparam int NL = 2;
`endif
    localparam int PW = IN_W + 1;

    typedef enum logic {WAIT_EPOCH, RUN} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    load;
    logic                    accumulate;
    logic                    dump;

    logic signed [ACC_W-1:0] acc     [NL];
    logic signed [ACC_W-1:0] sum     [NL];
    logic signed [ACC_W-1:0] res_q   [NL];
    logic [NL-1:0]           clip;
    logic [NL-1:0]           lane_code;
    logic [CNT_W-1:0]        samp_cnt;
    logic                    sat_acc;

    logic [CNT_W-1:0]        n_samp_q;
    logic [CNT_W-1:0]        epoch_cnt_q;
    logic                    sat_q;
    logic                    valid_q;
    logic                    overrun_q;

    // Sign-extend first so negating the most negative sample cannot wrap.
    function automatic logic [PW-1:0] code_wipe(input logic [IN_W-1:0] s, input logic c);
        logic [PW-1:0] ext;
        ext = {s[IN_W-1], s};
        return c ? -ext : ext;
    endfunction

    // Returns {clip, clamped sum}; overflow shows as disagreement of the top two bits of the
    // ACC_W+1 bit sum, and the clamp direction follows the true sign in the top bit.
    function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] base,
                                                input logic [PW-1:0]    prod);
        logic [ACC_W:0] full;
        full = {base[ACC_W-1], base} + {{(ACC_W + 1 - PW){prod[PW-1]}}, prod};
        if (full[ACC_W] != full[ACC_W-1]) begin
            return {1'b1, full[ACC_W], {(ACC_W - 1){~full[ACC_W]}}};
        end
        return {1'b0, full[ACC_W-1:0]};
    endfunction

`ifdef EARLY_LATE_EN
    assign lane_code = {late_code, late_code, early_code, early_code, promt_code, promt_code};
`else
    assign lane_code = {promt_code, promt_code};
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_EPOCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath controls; a disabled channel always falls back to WAIT_EPOCH.
    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        accumulate = 1'b0;
        dump       = 1'b0;
        if (!ch_en) begin
            state_nxt = WAIT_EPOCH;
        end else begin
            case (state)
                WAIT_EPOCH: begin
                    // The partial epoch before the first pulse is discarded: load, no dump.
                    if (dly_epoch) begin
                        state_nxt = RUN;
                        load      = 1'b1;
                    end
                end
                RUN: begin
                    if (dly_epoch) begin
                        dump = 1'b1;
                        load = 1'b1;
                    end else begin
                        accumulate = 1'b1;
                    end
                end
                default: state_nxt = WAIT_EPOCH;
            endcase
        end
    end

    // Per-lane product and saturating sum; a load starts from zero.
    always_comb begin
        logic [ACC_W:0]  step;
        logic [IN_W-1:0] samp;
        step = '0;
        samp = '0;
        clip = '0;
        for (int k = 0; k < NL; k++) begin
            samp    = k[0] ? q_in : i_in;
            step    = acc_step(load ? '0 : acc[k], code_wipe(samp, lane_code[k]));
            clip[k] = step[ACC_W];
            sum[k]  = step[ACC_W-1:0];
        end
    end

    // Accumulators: reload on pulse, integrate in RUN, otherwise held at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NL; k++) begin
                acc[k] <= '0;
            end
            samp_cnt <= '0;
            sat_acc  <= 1'b0;
        end else if (load) begin
            for (int k = 0; k < NL; k++) begin
                acc[k] <= sum[k];
            end
            samp_cnt <= CNT_W'(1);
            sat_acc  <= |clip;
        end else if (accumulate) begin
            for (int k = 0; k < NL; k++) begin
                acc[k] <= sum[k];
            end
            samp_cnt <= (&samp_cnt) ? samp_cnt : samp_cnt + 1'b1;
            sat_acc  <= sat_acc | (|clip);
        end else begin
            for (int k = 0; k < NL; k++) begin
                acc[k] <= '0;
            end
            samp_cnt <= '0;
            sat_acc  <= 1'b0;
        end
    end

    // Holding registers and handshake. Results/valid/overrun survive ch_en=0; epoch_cnt does not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NL; k++) begin
                res_q[k] <= '0;
            end
            n_samp_q    <= '0;
            epoch_cnt_q <= '0;
            sat_q       <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (dump) begin
                // The pulse sample belongs to the new epoch, so dump the pre-pulse sums.
                for (int k = 0; k < NL; k++) begin
                    res_q[k] <= acc[k];
                end
                n_samp_q    <= samp_cnt;
                sat_q       <= sat_acc;
                epoch_cnt_q <= epoch_cnt_q + 1'b1;
                valid_q     <= 1'b1;
                if (valid_q && !res.rd_ack) begin
                    overrun_q <= 1'b1;
                end else if (res.rd_ack) begin
                    overrun_q <= 1'b0;
                end
            end else if (res.rd_ack) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (!ch_en) begin
                epoch_cnt_q <= '0;
            end
        end
    end

    assign res.p_i          = res_q[0];
    assign res.p_q          = res_q[1];
`ifdef EARLY_LATE_EN
    assign res.e_i          = res_q[2];
    assign res.e_q          = res_q[3];
    assign res.l_i          = res_q[4];
    assign res.l_q          = res_q[5];
`endif
    assign res.n_samp       = n_samp_q;
    assign res.epoch_cnt    = epoch_cnt_q;
    assign res.sat          = sat_q;
    assign res.result_valid = valid_q;
    assign res.overrun      = overrun_q;
endmodule
